// File: rtl/fp_mult_pipe_if.sv
// fp_mult_pipe_if: operand/result handshake bundle for fp_mult_pipe.
//   in_valid / in_ready : operand pair transfer (master -> slave)
//   a, b                : operands {sign, exp, mant}, W = 1+EW+MW bits
//   out_valid / out_ready : result transfer (slave -> master)
//   result              : product word, W bits
//   flags               : {invalid, overflow, underflow, inexact}, qualified by out_valid
// The EW/MW parameters must match those of the fp_mult_pipe instance.
interface fp_mult_pipe_if #(
    parameter int EW = 5,
    parameter int MW = 10
);
    localparam int W = 1 + EW + MW;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: pipelined floating-point multiplier, round-to-nearest-even,
// subnormal inputs treated as zero, subnormal results flushed to zero.
//   CLK    : clock, rising edge
//   RESETn : asynchronous active-low reset, clears all valids and outputs
//   bus    : fp_mult_pipe_if slave (operands in, result + flags out)
// Register chain: operand capture -> unpack -> significand product ->
// normalise/round/pack into the output register. A single global stall
// (out_valid & !out_ready) freezes every register, so order is preserved.
module fp_mult_pipe #(
    parameter int EW = 5,
    parameter int MW = 10
) (
    input  logic          CLK,
    input  logic          RESETn,
    fp_mult_pipe_if.slave bus
);
    localparam int W  = 1 + EW + MW;
    localparam int PW = 2 * MW + 2;
    localparam int XW = EW + 2;

    localparam logic signed [XW-1:0] BIAS = XW'(2 ** (EW - 1) - 1);
    localparam logic signed [XW-1:0] EMAX = XW'(2 ** EW - 1);
    localparam logic signed [XW-1:0] ONE  = XW'(1);
    localparam logic signed [XW-1:0] ZERO = '0;
    localparam logic [EW-1:0]        EXP_ONES = '1;
    localparam logic [W-1:0]         QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    logic advance;

    assign advance      = ~(bus.out_valid & ~bus.out_ready);
    assign bus.in_ready = advance;

    // operand capture
    logic         v0;
    logic [W-1:0] a0, b0;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            v0 <= 1'b0;
            a0 <= '0;
            b0 <= '0;
        end else if (advance) begin
            v0 <= bus.in_valid;
            a0 <= bus.a;
            b0 <= bus.b;
        end
    end

    // unpack / classify
    logic [EW-1:0]        ea, eb;
    logic [MW-1:0]        ma, mb;
    logic                 za, zb, infa, infb, nana, nanb, snana, snanb, inf_zero;
    logic                 sgn_u;
    logic signed [XW-1:0] e_u;
    logic                 spc_u;
    logic [W-1:0]         spc_res_u;
    logic [3:0]           spc_flg_u;

    assign ea    = a0[W-2:MW];
    assign eb    = b0[W-2:MW];
    assign ma    = a0[MW-1:0];
    assign mb    = b0[MW-1:0];
    assign za    = (ea == '0);
    assign zb    = (eb == '0);
    assign infa  = (ea == EXP_ONES) && (ma == '0);
    assign infb  = (eb == EXP_ONES) && (mb == '0);
    assign nana  = (ea == EXP_ONES) && (ma != '0);
    assign nanb  = (eb == EXP_ONES) && (mb != '0);
    assign snana = nana & ~ma[MW-1];
    assign snanb = nanb & ~mb[MW-1];
    assign inf_zero = (infa & zb) | (infb & za);
    assign sgn_u = a0[W-1] ^ b0[W-1];
    assign e_u   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

    // special results are resolved here and carried alongside the datapath
    always_comb begin
        spc_u     = 1'b0;
        spc_res_u = '0;
        spc_flg_u = '0;
        if (nana | nanb | inf_zero) begin
            spc_u     = 1'b1;
            spc_res_u = QNAN;
            spc_flg_u = {inf_zero | snana | snanb, 3'b000};
        end else if (infa | infb) begin
            spc_u     = 1'b1;
            spc_res_u = {sgn_u, EXP_ONES, {MW{1'b0}}};
        end else if (za | zb) begin
            spc_u     = 1'b1;
            spc_res_u = {sgn_u, {(EW+MW){1'b0}}};
        end
    end

    logic                 v1, sgn1, spc1;
    logic signed [XW-1:0] e1;
    logic [MW:0]          siga1, sigb1;
    logic [W-1:0]         spc_res1;
    logic [3:0]           spc_flg1;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            v1       <= 1'b0;
            sgn1     <= 1'b0;
            spc1     <= 1'b0;
            e1       <= '0;
            siga1    <= '0;
            sigb1    <= '0;
            spc_res1 <= '0;
            spc_flg1 <= '0;
        end else if (advance) begin
            v1       <= v0;
            sgn1     <= sgn_u;
            spc1     <= spc_u;
            e1       <= e_u;
            siga1    <= {1'b1, ma};
            sigb1    <= {1'b1, mb};
            spc_res1 <= spc_res_u;
            spc_flg1 <= spc_flg_u;
        end
    end

    // significand product
    logic                 v2, sgn2, spc2;
    logic signed [XW-1:0] e2;
    logic [PW-1:0]        prod2;
    logic [W-1:0]         spc_res2;
    logic [3:0]           spc_flg2;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            v2       <= 1'b0;
            sgn2     <= 1'b0;
            spc2     <= 1'b0;
            e2       <= '0;
            prod2    <= '0;
            spc_res2 <= '0;
            spc_flg2 <= '0;
        end else if (advance) begin
            v2       <= v1;
            sgn2     <= sgn1;
            spc2     <= spc1;
            e2       <= e1;
            prod2    <= PW'(siga1) * PW'(sigb1);
            spc_res2 <= spc_res1;
            spc_flg2 <= spc_flg1;
        end
    end

    // normalise, round, pack
    // norm holds the hidden bit at its top (dropped), then mantissa, guard, sticky bits.
    logic                 msb, guard, sticky, rnd_up, carry, inexact;
    logic [PW-2:0]        norm;
    logic [MW-1:0]        mant_n, mant_r;
    logic signed [XW-1:0] e_f;
    logic [W-1:0]         res_c;
    logic [3:0]           flg_c;

    assign msb     = prod2[PW-1];
    assign norm    = msb ? prod2[PW-2:0] : {prod2[PW-3:0], 1'b0};
    assign mant_n  = norm[PW-2 -: MW];
    assign guard   = norm[MW];
    assign sticky  = |norm[MW-1:0];
    assign rnd_up  = guard & (sticky | mant_n[0]);
    assign {carry, mant_r} = {1'b0, mant_n} + {{MW{1'b0}}, rnd_up};
    // a rounding carry leaves mant_r at zero, i.e. significand 1.0 one binade up
    assign e_f     = e2 + (msb ? ONE : ZERO) + (carry ? ONE : ZERO);
    assign inexact = guard | sticky;

    always_comb begin
        res_c = {sgn2, e_f[EW-1:0], mant_r};
        flg_c = {3'b000, inexact};
        if (spc2) begin
            res_c = spc_res2;
            flg_c = spc_flg2;
        end else if (e_f >= EMAX) begin
            res_c = {sgn2, EXP_ONES, {MW{1'b0}}};
            flg_c = 4'b0101;
        end else if (e_f <= ZERO) begin
            res_c = {sgn2, {(EW+MW){1'b0}}};
            flg_c = 4'b0011;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.flags     <= '0;
        end else if (advance) begin
            bus.out_valid <= v2;
            bus.result    <= res_c;
            bus.flags     <= flg_c;
        end
    end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: self-checking bench for fp_mult_pipe. A binary16 instance
// is driven with directed and random traffic and checked against an
// integer-arithmetic reference model through a scoreboard; a binary32
// instance gets a short directed check.
module tb_fp_mult_pipe;
    logic CLK = 1'b0;
    logic RESETn = 1'b0;

    always #5 CLK = ~CLK;

    fp_mult_pipe_if #(.EW(5), .MW(10)) bus16 ();
    fp_mult_pipe_if #(.EW(8), .MW(23)) bus32 ();

    fp_mult_pipe #(.EW(5), .MW(10)) dut16 (.CLK(CLK), .RESETn(RESETn), .bus(bus16));
    fp_mult_pipe #(.EW(8), .MW(23)) dut32 (.CLK(CLK), .RESETn(RESETn), .bus(bus32));

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;
    int n_stall = 0;

    logic [19:0] exp_q[$];
    bit          prev_stall = 1'b0;
    bit          stall_now;
    logic [15:0] prev_res;
    logic [3:0]  prev_flg;
    logic [19:0] e_pop;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_vec++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp_v);
        end
    endtask

    // binary16 product from exact integer significand arithmetic; returns {flags, result}
    function automatic logic [19:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        int ex, ey, mx, my, p, sh, q, r, half, e;
        bit s, nx, ny, ix, iy, zx, zy, inv;
        ex = int'(x[14:10]);
        ey = int'(y[14:10]);
        mx = int'(x[9:0]);
        my = int'(y[9:0]);
        s  = x[15] ^ y[15];
        nx = (ex == 31) && (mx != 0);
        ny = (ey == 31) && (my != 0);
        ix = (ex == 31) && (mx == 0);
        iy = (ey == 31) && (my == 0);
        zx = (ex == 0);
        zy = (ey == 0);
        if (nx || ny || (ix && zy) || (iy && zx)) begin
            inv = (ix && zy) || (iy && zx) || (nx && mx < 512) || (ny && my < 512);
            return {inv, 3'b000, 16'h7E00};
        end
        if (ix || iy) return {4'b0000, s, 5'h1F, 10'h000};
        if (zx || zy) return {4'b0000, s, 15'h0000};
        p    = (1024 + mx) * (1024 + my);
        sh   = (p >= 2097152) ? 11 : 10;
        q    = p >> sh;
        r    = p - (q << sh);
        half = 1 << (sh - 1);
        if (r > half || (r == half && (q % 2) == 1)) q++;
        e = ex + ey - 15 + (sh - 10);
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        if (e >= 31) return {4'b0101, s, 5'h1F, 10'h000};
        if (e <= 0)  return {4'b0011, s, 15'h0000};
        return {3'b000, r != 0, s, e[4:0], q[9:0]};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        int sel;
        v   = 16'($urandom);
        sel = int'($urandom_range(0, 9));
        if (sel == 0) v[14:10] = 5'h1F;
        if (sel == 1) v[14:10] = 5'h00;
        if (sel == 2) v[14:10] = 5'h1E;
        if (sel == 3) v[14:10] = 5'h01;
        return v;
    endfunction

    // scoreboard, handshake and stall-hold monitor (binary16 instance)
    always @(negedge CLK) begin
        if (RESETn) begin
            if (bus16.in_valid && bus16.in_ready)
                exp_q.push_back(ref_mul(bus16.a, bus16.b));
            stall_now = bus16.out_valid && !bus16.out_ready;
            check_val("in_ready", 32'(bus16.in_ready), 32'(!stall_now));
            if (stall_now) n_stall++;
            if (stall_now && prev_stall) begin
                check_val("hold_res", 32'(bus16.result), 32'(prev_res));
                check_val("hold_flg", 32'(bus16.flags), 32'(prev_flg));
            end
            prev_stall = stall_now;
            prev_res   = bus16.result;
            prev_flg   = bus16.flags;
            if (bus16.out_valid && bus16.out_ready) begin
                n_out++;
                check_val("sb_pending", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    e_pop = exp_q.pop_front();
                    check_val("sb_res", 32'(bus16.result), 32'(e_pop[15:0]));
                    check_val("sb_flg", 32'(bus16.flags), 32'(e_pop[19:16]));
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_vec16(input string tag, input logic [15:0] x, input logic [15:0] y,
                             input logic [15:0] er, input logic [3:0] ef);
        int lat;
        @(posedge CLK); #1;
        bus16.a = x;
        bus16.b = y;
        bus16.in_valid = 1'b1;
        @(posedge CLK); #1;
        bus16.in_valid = 1'b0;
        lat = 0;
        while (!bus16.out_valid && lat < 10) begin
            @(posedge CLK); #1;
            lat++;
        end
        check_val({tag, "_lat"}, 32'(lat), 32'(3));
        check_val({tag, "_res"}, 32'(bus16.result), 32'(er));
        check_val({tag, "_flg"}, 32'(bus16.flags), 32'(ef));
    endtask

    task automatic run_vec32(input string tag, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] er, input logic [3:0] ef);
        int lat;
        @(posedge CLK); #1;
        bus32.a = x;
        bus32.b = y;
        bus32.in_valid = 1'b1;
        @(posedge CLK); #1;
        bus32.in_valid = 1'b0;
        lat = 0;
        while (!bus32.out_valid && lat < 10) begin
            @(posedge CLK); #1;
            lat++;
        end
        check_val({tag, "_lat"}, 32'(lat), 32'(3));
        check_val({tag, "_res"}, bus32.result, er);
        check_val({tag, "_flg"}, 32'(bus32.flags), 32'(ef));
    endtask

    task automatic drain16(input string tag);
        int cyc;
        @(posedge CLK); #1;
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check_val(tag, 32'(exp_q.size()), 32'(0));
    endtask

    logic [15:0] pa[8];
    logic [15:0] pb[8];

    initial begin
        int idx, out0, stall0;
        bit acc_prev;

        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.out_ready = 1'b1;

        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_out_valid", 32'(bus16.out_valid), 32'(0));
        check_val("rst_in_ready", 32'(bus16.in_ready), 32'(1));
        check_val("rst_result", 32'(bus16.result), 32'(0));
        check_val("rst_flags", 32'(bus16.flags), 32'(0));
        RESETn = 1'b1;

        run_vec16("mul_1p5sq", 16'h3E00, 16'h3E00, 16'h4080, 4'b0000);
        run_vec16("mul_neg2",  16'hC000, 16'h3C00, 16'hC000, 4'b0000);
        run_vec16("tie_up",    16'h3C01, 16'h3E00, 16'h3E02, 4'b0001);
        run_vec16("tie_even",  16'h3C03, 16'h3E00, 16'h3E04, 4'b0001);
        run_vec16("rnd_down",  16'h3C01, 16'h3C01, 16'h3C02, 4'b0001);
        run_vec16("inf_zero",  16'h7C00, 16'h0000, 16'h7E00, 4'b1000);
        run_vec16("ninf_x2",   16'hFC00, 16'h4000, 16'hFC00, 4'b0000);
        run_vec16("qnan",      16'h7E00, 16'h3C00, 16'h7E00, 4'b0000);
        run_vec16("snan",      16'h7D00, 16'h3C00, 16'h7E00, 4'b1000);
        run_vec16("daz",       16'h0001, 16'h3C00, 16'h0000, 4'b0000);
        run_vec16("overflow",  16'h7BFF, 16'h4000, 16'h7C00, 4'b0101);
        run_vec16("underflow", 16'h0400, 16'h3800, 16'h0000, 4'b0011);

        // random traffic with random valid / ready; operands change freely while not accepted
        for (int c = 0; c < 400; c++) begin
            @(posedge CLK); #1;
            bus16.in_valid  = ($urandom_range(0, 3) != 0);
            bus16.out_ready = ($urandom_range(0, 3) != 0);
            bus16.a = rand_op();
            bus16.b = rand_op();
        end
        drain16("rand_drain");

        // backpressure: 8 pairs, out_ready low for cycles 4..9
        for (int i = 0; i < 8; i++) begin
            pa[i] = rand_op();
            pb[i] = rand_op();
        end
        out0 = n_out;
        stall0 = n_stall;
        idx = 0;
        acc_prev = 1'b0;
        for (int c = 0; c < 60 && (idx < 8 || exp_q.size() != 0); c++) begin
            @(posedge CLK); #1;
            if (acc_prev) idx++;
            bus16.out_ready = !(c >= 4 && c <= 9);
            bus16.in_valid  = (idx < 8);
            if (idx < 8) begin
                bus16.a = pa[idx];
                bus16.b = pb[idx];
            end
            @(negedge CLK);
            acc_prev = bus16.in_valid && bus16.in_ready;
        end
        @(posedge CLK); #1;
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        check_val("bp_accepted", 32'(idx), 32'(8));
        check_val("bp_outputs", 32'(n_out - out0), 32'(8));
        check_val("bp_drained", 32'(exp_q.size()), 32'(0));
        check_val("bp_stalled", 32'(n_stall - stall0 >= 5), 32'(1));

        // reset with two operations in flight
        @(posedge CLK); #1;
        bus16.a = 16'h3E00; bus16.b = 16'h3E00; bus16.in_valid = 1'b1;
        @(posedge CLK); #1;
        bus16.a = 16'h4000; bus16.b = 16'h4000;
        @(posedge CLK); #1;
        bus16.in_valid = 1'b0;
        @(posedge CLK);
        @(posedge CLK); #1;
        check_val("rst_pre_valid", 32'(bus16.out_valid), 32'(1));
        RESETn = 1'b0;
        #1;
        check_val("rst_mid_valid", 32'(bus16.out_valid), 32'(0));
        check_val("rst_mid_result", 32'(bus16.result), 32'(0));
        exp_q.delete();
        out0 = n_out;
        repeat (2) @(posedge CLK);
        #1;
        RESETn = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        check_val("rst_no_output", 32'(n_out - out0), 32'(0));
        check_val("rst_post_valid", 32'(bus16.out_valid), 32'(0));

        run_vec16("post_rst", 16'h3E00, 16'h3E00, 16'h4080, 4'b0000);

        run_vec32("f32_1p5sq", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
        run_vec32("f32_neg2",  32'hC0000000, 32'h3F800000, 32'hC0000000, 4'b0000);

        repeat (3) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
